// File: rtl/anchor_feature_collector.sv
// anchor_feature_collector
// Reassembles FEATURE_LENTH beats of DATA_BUS_WIDTH bits from the octree
// searcher into one anchor feature word. Two ping-pong slots let beat
// collection continue while the rendering stage holds an assembled anchor.

module anchor_feature_collector #(
  parameter int DATA_BUS_WIDTH = 64,
  parameter int FEATURE_LENTH  = 9,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear,
  input  logic [DATA_BUS_WIDTH-1:0]               feat_in,
  input  logic                                    feat_ready,
  output logic                                    feat_valid,
  input  logic                                    search_done,
  output logic [FEATURE_LENTH*DATA_BUS_WIDTH-1:0] anchor_data,
  output logic                                    anchor_valid,
  input  logic                                    anchor_ready,
  output logic [CNT_WIDTH-1:0]                    anchor_cnt,
  output logic                                    frame_err
);

  localparam int IDX_W = (FEATURE_LENTH > 1) ? $clog2(FEATURE_LENTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_LENTH - 1);

  // Each slot is an array of beats; beat 0 sits in the LSBs of the flat word.
  typedef logic [FEATURE_LENTH-1:0][DATA_BUS_WIDTH-1:0] anchor_t;

  anchor_t              slot_q [2];
  logic [1:0]           full_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [IDX_W-1:0]     beat_idx_q;
  logic [CNT_WIDTH-1:0] anchor_cnt_q;
  logic                 frame_err_q;

  logic accept;
  logic completes;
  logic abort;
  logic wr_en;
  logic take;

  // Handshake outputs come straight from registers so feat_valid never
  // depends on feat_ready.
  assign feat_valid   = ~full_q[wr_ptr_q];
  assign anchor_valid = full_q[rd_ptr_q];
  assign anchor_data  = slot_q[rd_ptr_q];
  assign anchor_cnt   = anchor_cnt_q;
  assign frame_err    = frame_err_q;

  // Decode this cycle's beat/anchor events.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise a latch is inferred.
  always_comb begin
    accept    = feat_ready && feat_valid;
    completes = accept && (beat_idx_q == LAST_IDX);
    // A search ending with a partial anchor in flight (including a stray
    // beat arriving at index 0 together with search_done) discards it.
    abort     = search_done && !completes && ((beat_idx_q != '0) || accept);
    wr_en     = accept && !abort;
    take      = anchor_valid && anchor_ready;
  end

  // Slot storage: write the accepted beat into the slot being filled.
  // NOTE: the slot array is reset as well, because anchor_data is visible
  // on the port and must read zero out of reset and after clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else if (wr_en) begin
      slot_q[wr_ptr_q][beat_idx_q] <= feat_in;
    end
  end

  // Slot full flags and ping-pong pointers; a fill and a take always hit
  // different slots, so both updates can be applied independently.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (clear) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (completes) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (take) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
    end
  end

  // Beat index within the anchor being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q <= '0;
    end else if (clear || abort || completes) begin
      beat_idx_q <= '0;
    end else if (accept) begin
      beat_idx_q <= beat_idx_q + 1'b1;
    end
  end

  // Delivered-anchor counter (wraps) and sticky framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anchor_cnt_q <= '0;
      frame_err_q  <= 1'b0;
    end else if (clear) begin
      anchor_cnt_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      if (take)  anchor_cnt_q <= anchor_cnt_q + 1'b1;
      if (abort) frame_err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_anchor_feature_collector.sv
// Self-checking bench for anchor_feature_collector: directed scenarios plus
// random traffic, all compared against a queue-based reference model.

module tb_anchor_feature_collector;

  localparam int W  = 64;
  localparam int L  = 9;
  localparam int CW = 16;
  localparam int AW = W * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [W-1:0]  feat_in;
  logic          feat_ready;
  logic          feat_valid;
  logic          search_done;
  logic [AW-1:0] anchor_data;
  logic          anchor_valid;
  logic          anchor_ready;
  logic [CW-1:0] anchor_cnt;
  logic          frame_err;

  always #5 clk = ~clk;

  anchor_feature_collector #(
    .DATA_BUS_WIDTH(W),
    .FEATURE_LENTH (L),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .feat_in     (feat_in),
    .feat_ready  (feat_ready),
    .feat_valid  (feat_valid),
    .search_done (search_done),
    .anchor_data (anchor_data),
    .anchor_valid(anchor_valid),
    .anchor_ready(anchor_ready),
    .anchor_cnt  (anchor_cnt),
    .frame_err   (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed anchors waiting for the consumer, beats of
  // the anchor in progress, delivered count and sticky error.
  logic [AW-1:0] m_q[$];
  logic [W-1:0]  m_part[$];
  logic [CW-1:0] m_cnt;
  bit            m_err;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  // Apply the currently driven inputs to the model for one clock edge.
  task automatic model_update(output bit acc);
    bit            take;
    bit            done;
    logic [AW-1:0] a;
    acc = feat_ready && (m_q.size() < 2);
    if (clear) begin
      model_reset();
      acc = 1'b0;
      return;
    end
    take = anchor_ready && (m_q.size() > 0);
    if (take) begin
      void'(m_q.pop_front());
      m_cnt++;
    end
    done = 1'b0;
    if (acc) begin
      m_part.push_back(feat_in);
      if (m_part.size() == L) begin
        a = '0;
        for (int i = 0; i < L; i++) a[i*W +: W] = m_part[i];
        m_q.push_back(a);
        m_part.delete();
        done = 1'b1;
      end
    end
    if (search_done && !done && (m_part.size() > 0)) begin
      m_err = 1'b1;
      m_part.delete();
    end
  endtask

  task automatic compare_outputs();
    check("feat_valid", feat_valid, m_q.size() < 2);
    check("anchor_valid", anchor_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("anchor_data", anchor_data, m_q[0]);
    check("anchor_cnt", anchor_cnt, m_cnt);
    check("frame_err", frame_err, m_err);
  endtask

  // One cycle: compare on the falling edge, then drive the next inputs.
  task automatic step(input logic fr, input logic [W-1:0] fin, input logic ar,
                      input logic sd, input logic clr, output bit acc);
    @(negedge clk);
    compare_outputs();
    feat_ready   = fr;
    feat_in      = fin;
    anchor_ready = ar;
    search_done  = sd;
    clear        = clr;
    model_update(acc);
  endtask

  task automatic idle(input logic ar);
    bit acc;
    step(1'b0, '0, ar, 1'b0, 1'b0, acc);
  endtask

  task automatic do_clear();
    bit acc;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Stream n beats with values base, base+1, ...; each beat is held until
  // accepted. Optionally raise search_done alongside the last beat.
  task automatic send(input int n, input logic [W-1:0] base, input logic ar, input logic sd_last);
    int sent = 0;
    bit acc;
    for (int c = 0; c < 40 * n + 50 && sent < n; c++) begin
      step(1'b1, base + W'(sent), ar, sd_last && (sent == n - 1), 1'b0, acc);
      if (acc) sent++;
    end
    check("send_done", sent, n);
  endtask

  task automatic drain();
    repeat (4) idle(1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    feat_ready   = 1'b0;
    anchor_ready = 1'b0;
    search_done  = 1'b0;
    clear        = 1'b0;
    feat_in      = '0;
    model_reset();
    #1;
    compare_outputs();
    check("rst_anchor_data", anchor_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    clear = 1'b0;
    feat_in = '0;
    feat_ready = 1'b0;
    search_done = 1'b0;
    anchor_ready = 1'b0;
    model_reset();
    #12;
    compare_outputs();
    check("reset_anchor_data", anchor_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single anchor: beats k = 0..8, consumer always ready.
    send(L, '0, 1'b1, 1'b0);
    idle(1'b1);
    check("single_valid", anchor_valid, 1'b1);
    for (int k = 0; k < L; k++) check("single_beat", anchor_data[k*W +: W], W'(k));
    idle(1'b1);
    check("single_cnt", anchor_cnt, 1);

    // Back-pressure: two slots fill, the third anchor stalls.
    do_clear();
    send(2 * L, 64'd100, 1'b0, 1'b0);
    idle(1'b0);
    check("bp_feat_valid", feat_valid, 1'b0);
    check("bp_anchor_valid", anchor_valid, 1'b1);
    repeat (3) step(1'b1, 64'd118, 1'b0, 1'b0, 1'b0, acc);
    check("bp_stalled", feat_valid, 1'b0);
    send(L, 64'd118, 1'b1, 1'b0);
    drain();
    check("bp_cnt", anchor_cnt, 3);

    // Simultaneous fill of anchor 2 and take of anchor 1.
    do_clear();
    send(L, 64'd200, 1'b0, 1'b0);
    send(L - 1, 64'd209, 1'b0, 1'b0);
    step(1'b1, 64'd217, 1'b1, 1'b0, 1'b0, acc);
    idle(1'b0);
    check("sim_valid", anchor_valid, 1'b1);
    check("sim_beat0", anchor_data[W-1:0], 64'd209);
    check("sim_cnt", anchor_cnt, 1);
    drain();

    // Partial anchor followed by search_done.
    do_clear();
    send(5, 64'd300, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1);
    check("partial_err", frame_err, 1'b1);
    send(L, 64'd400, 1'b0, 1'b0);
    idle(1'b0);
    check("partial_beat0", anchor_data[W-1:0], 64'd400);
    drain();
    check("partial_cnt", anchor_cnt, 1);

    // search_done together with the final beat is legal.
    do_clear();
    send(L, 64'd500, 1'b1, 1'b1);
    idle(1'b1);
    check("last_err", frame_err, 1'b0);
    drain();
    check("last_cnt", anchor_cnt, 1);

    // clear mid-anchor.
    send(4, 64'd600, 1'b1, 1'b0);
    do_clear();
    idle(1'b1);
    check("clr_valid", anchor_valid, 1'b0);
    check("clr_feat_valid", feat_valid, 1'b1);
    check("clr_cnt", anchor_cnt, 0);
    check("clr_data", anchor_data, '0);
    send(L, 64'd700, 1'b0, 1'b0);
    idle(1'b0);
    check("clr_beat0", anchor_data[W-1:0], 64'd700);
    drain();

    // Asynchronous reset mid-anchor.
    send(4, 64'd800, 1'b1, 1'b0);
    async_reset();
    idle(1'b1);
    check("rst_cnt", anchor_cnt, 0);
    send(L, 64'd900, 1'b0, 1'b0);
    idle(1'b0);
    check("rst_beat0", anchor_data[W-1:0], 64'd900);
    drain();

    // Random traffic.
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0, acc);
    end
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anchor_feature_collector.md
# anchor_feature_collector

Sits directly downstream of the octree search path. It consumes the `DATA_BUS_WIDTH`-bit feature beat stream that the searcher emits, `FEATURE_LENTH` beats per anchor. It reassembles each group of beats into one full-width anchor feature word and hands that word to the rendering stage through a standard valid/ready handshake. Two anchor slots (ping-pong) let collection continue while the consumer holds an assembled anchor.

## Interface
Parameters:
- `DATA_BUS_WIDTH`, 64: width of one feature beat.
- `FEATURE_LENTH`, 9: beats per anchor feature (36 × 16 bit = 9 × 64).
- `CNT_WIDTH`, 16: width of the delivered-anchor counter.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `clear`, input, 1: synchronous clear of all state; highest priority.
- `feat_in`, input, `DATA_BUS_WIDTH`: feature beat from the searcher (its `feature_out`).
- `feat_ready`, input, 1: a beat is present on `feat_in` (the searcher's `out_ready`).
- `feat_valid`, output, 1: the collector accepts a beat this cycle (drives the searcher's `out_valid`).
- `search_done`, input, 1: one-cycle pulse marking the end of a search pass.
- `anchor_data`, output, `FEATURE_LENTH*DATA_BUS_WIDTH`: assembled anchor feature.
- `anchor_valid`, output, 1: `anchor_data` holds a complete anchor.
- `anchor_ready`, input, 1: the consumer takes the anchor.
- `anchor_cnt`, output, `CNT_WIDTH`: number of anchors delivered since reset or clear.
- `frame_err`, output, 1: sticky flag; a search ended with a partial anchor.

## Operation
State:
- two slots, `slot[0..1]`, each `FEATURE_LENTH*DATA_BUS_WIDTH` wide;
- per-slot `full` flags;
- pointers `wr_ptr` and `rd_ptr`, 1 bit each;
- `beat_idx`, range 0..`FEATURE_LENTH`-1.

Beat side:
- `feat_valid = ~full[wr_ptr]`. This is combinational from registers only and never depends on `feat_ready`.
- Beat accept: `feat_ready && feat_valid`.
  - `feat_in` is written to `slot[wr_ptr][beat_idx*DATA_BUS_WIDTH +: DATA_BUS_WIDTH]`. Beat 0 goes to the LSBs.
  - `beat_idx` increments.
- Accepting beat `FEATURE_LENTH`-1:
  - sets `full[wr_ptr]`;
  - toggles `wr_ptr`;
  - sets `beat_idx` to 0.

Anchor side:
- `anchor_valid = full[rd_ptr]` and `anchor_data = slot[rd_ptr]`.
- Anchor take: `anchor_valid && anchor_ready`.
  - clears `full[rd_ptr]`;
  - toggles `rd_ptr`;
  - increments `anchor_cnt`, which wraps modulo 2^`CNT_WIDTH`.
- Slot contents are not cleared on a take; only the flag is cleared.

Simultaneous events:
- A fill completing on one slot and a take on the other in the same cycle are both performed.
- The same slot can never be filled and taken in one cycle, by construction.

`search_done` handling:
- Let `completes` = accept of beat `FEATURE_LENTH`-1 in the same cycle.
- If `search_done` arrives with `beat_idx != 0` and not `completes`:
  - `frame_err` sets to 1;
  - `beat_idx` returns to 0 and the partial anchor is discarded, including any beat accepted that cycle.
  - `full` flags and pointers are unchanged.
- If `search_done` arrives with `beat_idx == 0` and no accept, it has no effect.
- If `search_done` arrives with `beat_idx == 0` together with an accept, this is a stray beat: `frame_err` sets to 1 and `beat_idx` stays 0.

`clear`:
- Zeroes `full`, both pointers, `beat_idx`, `anchor_cnt` and `frame_err`.
- Any beat accept or anchor take in that cycle is ignored.

## Timing
Reset values (asynchronous, on `rst_n` low):
- `anchor_valid` = 0, `anchor_data` = 0, `anchor_cnt` = 0, `frame_err` = 0;
- `feat_valid` = 1, because both slots are empty;
- all slots, flags, pointers and `beat_idx` = 0.

Latency and throughput:
- `anchor_valid` rises in the cycle after the final beat is accepted.
- An anchor is held stable while `anchor_valid && !anchor_ready`.
- `anchor_valid` drops in the cycle after a take unless the other slot is full, in which case the next anchor appears with no gap.
- With both slots full, `feat_valid` = 0 until a take occurs; `feat_valid` returns to 1 in the cycle after the take.
- Sustained throughput is 1 beat per cycle while the consumer takes each anchor within `FEATURE_LENTH` cycles.

Reset mid-anchor:
- `rst_n` or `clear` asserted mid-anchor drops all partial and complete data.
- No anchor is emitted for that data and no error is flagged.

## Test plan
- **Single anchor:** reset, then hold `feat_ready` = 1 with `feat_in` = k for beats k = 0..8 and `anchor_ready` = 1. Required:
  - `anchor_valid` = 1 exactly 1 cycle after beat 8;
  - `anchor_data[k*64+:64]` = k for every k;
  - `anchor_cnt` = 1.
- **Back-pressure:** `anchor_ready` = 0, stream 27 beats. Required:
  - two slots fill and `feat_valid` = 0 after beat 18;
  - beats 18..26 stall;
  - after raising `anchor_ready`, three anchors are delivered in order and `anchor_cnt` = 3.
- **Simultaneous fill/take:** the final beat of anchor 2 is accepted in the same cycle anchor 1 is taken. Required:
  - both events take effect;
  - `anchor_valid` stays 1 with anchor 2 data on the next cycle.
- **Partial anchor:** 5 beats, then a `search_done` pulse. Required:
  - `frame_err` = 1;
  - the next 9 beats form a correct anchor starting at beat 0;
  - `anchor_cnt` counts only complete anchors.
- **`search_done` on the last beat:** `search_done` in the same cycle as beat 8 is accepted. Required: `frame_err` stays 0 and the anchor is delivered.
- **Reset/clear mid-anchor:** assert `clear` after 4 beats, and separately pulse `rst_n` low asynchronously after 4 beats. Required:
  - all outputs return to reset values;
  - `anchor_cnt` = 0;
  - the next anchor assembles from beat 0.
